instr_mem_boot: RTL and testbench
=================================

Name: instr_mem_boot

Overview:
- Word-addressed instruction memory with a boot-load front end. It sits directly downstream of the PC register: it consumes the registered PC and returns the instruction word in the same cycle, as the single-cycle datapath requires.
- After reset, a host streams the program in over a valid/ready word interface. The block then raises fetch_en so the core may start fetching.
- Unloaded, misaligned and out-of-range fetches return a deterministic NOP (32'h0000_0000).

Parameters:
- DEPTH, 256, number of 32-bit instruction words.
- ADDR_W, 8, word-index width; DEPTH must equal 2**ADDR_W.
- NOP_WORD, 32'h0000_0000, word returned for any invalid fetch.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  reset, asynchronous, active-low.
- pc  in  32  byte address from the PC register.
- load_valid  in  1  host presents load_data.
- load_data  in  32  instruction word to store at the next load slot.
- load_last  in  1  qualifies the final word of the image; sampled with load_valid.
- load_ready  out  1  block accepts a load word this cycle.
- reload  in  1  single-cycle request to discard the image and re-enter LOAD.
- fetch_en  out  1  high only in RUN; gates PC update and the core.
- instruction  out  32  combinational instruction for pc.
- fetch_fault  out  1  combinational; high in RUN when the fetch is misaligned or beyond the loaded image.
- loaded_words  out  ADDR_W+1  count of valid words in the image (0..DEPTH).

Behaviour:
- States: LOAD, RUN. Encoded in 1 bit.
- Reset (async assert, reset==0) forces:
  - state=LOAD, wr_ptr=0, loaded_words=0.
  - load_ready=1 once reset is released; fetch_en=0.
  - Memory array is not reset.
- LOAD:
  - load_ready=1.
  - A word is accepted when load_valid && load_ready. On acceptance, mem[wr_ptr]<=load_data, wr_ptr<=wr_ptr+1, loaded_words<=loaded_words+1.
  - Transition to RUN on the edge that accepts a word with load_last=1, or accepts the word at wr_ptr==DEPTH-1 (auto-terminate; loaded_words=DEPTH).
  - load_last without load_valid has no effect.
  - Zero-length images are not possible; RUN needs at least one word.
- RUN:
  - load_ready=0; fetch_en=1.
  - load_valid and load_data are ignored and the memory is never written.
- reload:
  - In RUN, reload=1 moves to LOAD next edge with wr_ptr=0 and loaded_words=0; fetch_en drops on that same edge.
  - In LOAD, reload=1 restarts the load: wr_ptr=0, loaded_words=0, and any word offered that cycle is discarded.
  - reload has priority over a simultaneous load acceptance.
- Fetch (combinational, zero latency):
  - idx = pc[ADDR_W+1:2].
  - valid_fetch = (state==RUN) && (pc[1:0]==0) && (pc[31:ADDR_W+2]==0) && (idx < loaded_words).
  - instruction = valid_fetch ? mem[idx] : NOP_WORD.
  - fetch_fault = (state==RUN) && !valid_fetch.
  - In LOAD, instruction=NOP_WORD and fetch_fault=0.
- Reset mid-load:
  - Partial image is abandoned and loaded_words=0.
  - Stale memory contents are unreachable because fetches are bounded by loaded_words.
- Width rules:
  - wr_ptr is ADDR_W bits and is not incremented past DEPTH-1; it is frozen on transition to RUN.
  - loaded_words is ADDR_W+1 bits, so DEPTH is representable.

Decomposition:
- Shared package mips_pkg:
  - NOP_WORD constant.
  - Instruction width constant INSTR_W=32.
  - State enum {LOAD, RUN}.
- One sub-module: imem_array. A DEPTH x 32 array with one synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
- instr_mem_boot holds the FSM, pointer, counter and fetch validation.

Test Plan:
- Reset, then load 4 words 0x20080005, 0x20090003, 0x01095020, 0xAC0A0000 with load_last on the 4th:
  - load_ready=0 and fetch_en=1 on the edge after the 4th word.
  - loaded_words=4.
  - pc=0x8 -> instruction=0x01095020.
- Same image, pc=0x10 (idx 4 >= loaded_words) -> instruction=0x00000000, fetch_fault=1.
- pc=0x6 -> NOP and fetch_fault=1. pc=0x0000_0400 (beyond DEPTH) -> NOP and fetch_fault=1.
- Stream 256 words with load_last=0 (word i = i):
  - RUN entered after word 255; loaded_words=256.
  - pc=0x3FC -> 0x000000FF.
  - Further load_valid is ignored.
- In RUN, pulse reload while load_valid=1 with data 0xDEADBEEF:
  - State goes to LOAD, loaded_words=0, and the word is not written.
  - Then load 1 word 0x11111111 with load_last -> pc=0 returns 0x11111111, and pc=4 returns NOP.
- Assert reset low asynchronously after 2 of 5 words:
  - fetch_en=0 and loaded_words=0 immediately.
  - After release, reload 1 word -> pc=4 returns NOP (stale word unreachable).

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_pkg : shared instruction width, NOP encoding and boot FSM states
// Rev 1.0
// ---------------------------------------------------------------------------
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/instr_mem_boot_imem_array.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imem_array : DEPTH x INSTR_W storage, synchronous write, asynchronous read
// Rev 1.0
// ---------------------------------------------------------------------------
module imem_array
  import mips_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  // No reset: reachability is bounded by the loaded word count upstream.
  logic [INSTR_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/instr_mem_boot.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instr_mem_boot : boot-loaded instruction memory with zero-latency fetch
// Rev 1.0
// ---------------------------------------------------------------------------
module instr_mem_boot
  import mips_pkg::*;
#(
  parameter int                 DEPTH    = 256,
  parameter int                 ADDR_W   = 8,
  parameter logic [INSTR_W-1:0] NOP_WORD = mips_pkg::NOP_WORD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        pc,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               load_last,
  output logic               load_ready,
  input  logic               reload,
  output logic               fetch_en,
  output logic [INSTR_W-1:0] instruction,
  output logic               fetch_fault,
  output logic [ADDR_W:0]    loaded_words
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] w_wr_ptr_nxt;
  logic [ADDR_W:0]   r_cnt;
  logic [ADDR_W:0]   w_cnt_nxt;
  logic              w_we;
  logic              w_accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= LOAD;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_wr_ptr_nxt = r_wr_ptr;
    w_cnt_nxt    = r_cnt;
    w_we         = 1'b0;
    load_ready   = (r_state == LOAD) && reset;
    fetch_en     = (r_state == RUN);
    w_accept     = load_valid && load_ready;
    case (r_state)
      LOAD: begin
        // reload wins over a word offered in the same cycle
        if (reload) begin
          w_wr_ptr_nxt = '0;
          w_cnt_nxt    = '0;
        end else if (w_accept) begin
          w_we      = 1'b1;
          w_cnt_nxt = r_cnt + (ADDR_W+1)'(1);
          if (load_last || (r_wr_ptr == ADDR_W'(DEPTH-1))) begin
            w_state_nxt = RUN;
          end else begin
            w_wr_ptr_nxt = r_wr_ptr + ADDR_W'(1);
          end
        end
      end
      RUN: begin
        if (reload) begin
          w_state_nxt  = LOAD;
          w_wr_ptr_nxt = '0;
          w_cnt_nxt    = '0;
        end
      end
      default: begin
        w_state_nxt = LOAD;
      end
    endcase
  end

  logic [ADDR_W-1:0]  w_idx;
  logic [INSTR_W-1:0] w_rdata;
  logic               w_valid_fetch;

  assign w_idx = pc[ADDR_W+1:2];

  // Index bound by loaded count keeps stale words from earlier images hidden.
  assign w_valid_fetch = (r_state == RUN) && (pc[1:0] == 2'b00)
                       && (pc[31:ADDR_W+2] == '0)
                       && ({1'b0, w_idx} < r_cnt);

  assign instruction  = w_valid_fetch ? w_rdata : NOP_WORD;
  assign fetch_fault  = (r_state == RUN) && !w_valid_fetch;
  assign loaded_words = r_cnt;

  imem_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_imem_array (
    .clk   (clk),
    .we    (w_we),
    .waddr (r_wr_ptr),
    .wdata (load_data),
    .raddr (w_idx),
    .rdata (w_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_boot.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_instr_mem_boot : directed stimulus checked against a behavioural model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_instr_mem_boot;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = '0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic        reload = 1'b0;
  logic        fetch_en;
  logic [31:0] instruction;
  logic        fetch_fault;
  logic [8:0]  loaded_words;

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  instr_mem_boot dut (
    .clk          (clk),
    .reset        (reset),
    .pc           (pc),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_last    (load_last),
    .load_ready   (load_ready),
    .reload       (reload),
    .fetch_en     (fetch_en),
    .instruction  (instruction),
    .fetch_fault  (fetch_fault),
    .loaded_words (loaded_words)
  );

  always #5 clk = ~clk;

  // Model: image as an array plus a word count and a running flag.
  logic [31:0] m_mem [256];
  int          m_cnt = 0;
  bit          m_run = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_run = 1'b0;
      m_cnt = 0;
    end else if (reload) begin
      m_run = 1'b0;
      m_cnt = 0;
    end else if (!m_run && load_valid) begin
      m_mem[m_cnt] = load_data;
      m_cnt++;
      if (load_last || m_cnt == 256) m_run = 1'b1;
    end
  end

  function automatic logic [31:0] exp_instr();
    longint widx = longint'(pc) / 4;
    if (m_run && (pc % 4 == 0) && widx < m_cnt) return m_mem[int'(widx)];
    return 32'h0000_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    #4;
    if (checking) begin
      chk("m_load_ready", 32'(load_ready), 32'(!m_run && reset));
      chk("m_fetch_en", 32'(fetch_en), 32'(m_run));
      chk("m_loaded_words", 32'(loaded_words), 32'(m_cnt));
      chk("m_instruction", instruction, exp_instr());
      chk("m_fetch_fault", 32'(fetch_fault), 32'(m_run && exp_instr() == 32'h0 &&
          !((pc % 4 == 0) && (longint'(pc) / 4 < m_cnt))));
    end
  end

  task automatic drive(input logic v, input logic [31:0] d, input logic l, input logic r);
    @(negedge clk);
    load_valid = v;
    load_data  = d;
    load_last  = l;
    reload     = r;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] ei, input logic ef);
    @(negedge clk);
    pc = a;
    #1;
    chk("lit_instruction", instruction, ei);
    chk("lit_fetch_fault", 32'(fetch_fault), 32'(ef));
  endtask

  initial begin
    #1 reset = 1'b0;
    #1;
    chk("lit_reset_fetch_en", 32'(fetch_en), 32'h0);
    chk("lit_reset_loaded", 32'(loaded_words), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    checking = 1'b1;
    #1 chk("lit_reset_load_ready", 32'(load_ready), 32'h1);

    // Four-word image terminated by load_last
    drive(1'b1, 32'h2008_0005, 1'b0, 1'b0);
    drive(1'b1, 32'h2009_0003, 1'b0, 1'b0);
    drive(1'b1, 32'h0109_5020, 1'b0, 1'b0);
    drive(1'b1, 32'hAC0A_0000, 1'b1, 1'b0);
    idle();
    #2;
    chk("lit_run_load_ready", 32'(load_ready), 32'h0);
    chk("lit_run_fetch_en", 32'(fetch_en), 32'h1);
    chk("lit_loaded_4", 32'(loaded_words), 32'd4);
    fetch(32'h0000_0008, 32'h0109_5020, 1'b0);
    fetch(32'h0000_0000, 32'h2008_0005, 1'b0);
    fetch(32'h0000_0010, 32'h0000_0000, 1'b1);
    fetch(32'h0000_0006, 32'h0000_0000, 1'b1);
    fetch(32'h0000_0400, 32'h0000_0000, 1'b1);

    // Full 256-word image, auto-terminated
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 256; i++) drive(1'b1, 32'(i), 1'b0, 1'b0);
    drive(1'b1, 32'hCAFE_BABE, 1'b0, 1'b0);
    drive(1'b1, 32'hCAFE_BABE, 1'b1, 1'b0);
    idle();
    #2;
    chk("lit_loaded_256", 32'(loaded_words), 32'd256);
    chk("lit_full_fetch_en", 32'(fetch_en), 32'h1);
    fetch(32'h0000_03FC, 32'h0000_00FF, 1'b0);
    fetch(32'h0000_0004, 32'h0000_0001, 1'b0);
    fetch(32'h0000_0400, 32'h0000_0000, 1'b1);

    // reload in RUN beats a simultaneous load word
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
    idle();
    #2;
    chk("lit_reload_fetch_en", 32'(fetch_en), 32'h0);
    chk("lit_reload_loaded", 32'(loaded_words), 32'h0);
    chk("lit_reload_ready", 32'(load_ready), 32'h1);
    fetch(32'h0000_0000, 32'h0000_0000, 1'b0);
    drive(1'b1, 32'h1111_1111, 1'b1, 1'b0);
    idle();
    #2 chk("lit_loaded_1", 32'(loaded_words), 32'd1);
    fetch(32'h0000_0000, 32'h1111_1111, 1'b0);
    fetch(32'h0000_0004, 32'h0000_0000, 1'b1);

    // reload inside LOAD discards the offered word
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    drive(1'b1, 32'h5555_5555, 1'b0, 1'b0);
    drive(1'b1, 32'h6666_6666, 1'b0, 1'b1);
    drive(1'b1, 32'h7777_7777, 1'b1, 1'b0);
    idle();
    #2 chk("lit_restart_loaded", 32'(loaded_words), 32'd1);
    fetch(32'h0000_0000, 32'h7777_7777, 1'b0);

    // Asynchronous reset after 2 of 5 words
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    drive(1'b1, 32'hA000_0000, 1'b0, 1'b0);
    drive(1'b1, 32'hA000_0001, 1'b0, 1'b0);
    drive(1'b1, 32'hA000_0002, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("lit_async_fetch_en", 32'(fetch_en), 32'h0);
    chk("lit_async_loaded", 32'(loaded_words), 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    reset = 1'b1;
    drive(1'b1, 32'h2222_2222, 1'b1, 1'b0);
    idle();
    #2 chk("lit_post_reset_loaded", 32'(loaded_words), 32'd1);
    fetch(32'h0000_0004, 32'h0000_0000, 1'b1);
    fetch(32'h0000_0000, 32'h2222_2222, 1'b0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
